// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter generator.
//   pc_sel_e              : next-PC source selected each cycle
//   RESET_VECTOR_DEFAULT  : default PC loaded on reset
//   INCR_DEFAULT          : default sequential increment in bytes
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_HOLD     = 2'd0,
    PC_SEL_SEQ      = 2'd1,
    PC_SEL_REDIRECT = 2'd2,
    PC_SEL_TRAP     = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          INCR_DEFAULT         = 4;

endpackage

// File: rtl/pc_incr.sv
// Sequential next-PC adder.
//   pc          : current fetch PC
//   pc_plus_inc : pc + INCR, wrapping modulo 2^XLEN (no overflow flag)
module pc_incr #(
  parameter int XLEN = 32,
  parameter int INCR = pc_pkg::INCR_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc
);

  assign pc_plus_inc = pc + XLEN'(INCR);

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator for the rv32im fetch stage.
// Holds the fetch PC and picks the next value from trap, redirect or the
// sequential path, presenting it to fetch through a valid/ready handshake.
//   clk, rst         : clock, synchronous active-high reset
//   stall            : hold the PC (hazard / load-use)
//   redirect_valid   : branch/jump taken, destination on redirect_target
//   trap_valid       : trap entry or mret, destination on trap_target
//   fetch_ready      : fetch accepts the presented PC
//   pc, pc_valid     : PC presented to fetch
//   pc_plus_inc      : pc + INCR (combinational)
//   flush            : one-cycle pulse after an accepted redirect or trap
//   misalign_err     : one-cycle pulse after a misaligned redirect
//   misalign_addr    : last misaligned redirect target
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              INCR         = INCR_DEFAULT,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            flush,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [0:0] RESET_HOLD = 1'b0;
  localparam logic [0:0] RUN        = 1'b1;

  logic [0:0]      state;
  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc_next;
  logic            redirect_aligned;
  logic            redirect_misaligned;

  assign pc_valid = (state == RUN);

  pc_incr #(
    .XLEN (XLEN),
    .INCR (INCR)
  ) u_pc_incr (
    .pc          (pc),
    .pc_plus_inc (pc_plus_inc)
  );

  assign redirect_aligned    = redirect_valid &&
                               (redirect_target[ALIGN_BITS-1:0] == '0);
  // A simultaneous trap discards the redirect, so it cannot raise an error.
  assign redirect_misaligned = redirect_valid && !redirect_aligned && !trap_valid;

  // Next-PC source selection, highest priority first
  always_comb begin
    pc_sel = PC_SEL_HOLD;
    if (trap_valid)
      pc_sel = PC_SEL_TRAP;
    else if (redirect_aligned)
      pc_sel = PC_SEL_REDIRECT;
    else if (redirect_valid || stall)
      pc_sel = PC_SEL_HOLD;
    else if (pc_valid && fetch_ready)
      pc_sel = PC_SEL_SEQ;
  end

  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_SEL_TRAP:     pc_next = trap_target;
      PC_SEL_REDIRECT: pc_next = redirect_target;
      PC_SEL_SEQ:      pc_next = pc_plus_inc;
      default:         pc_next = pc;
    endcase
  end

  // Registered PC, FSM and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_HOLD;
      pc            <= RESET_VECTOR;
      flush         <= 1'b0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state        <= RUN;
      pc           <= pc_next;
      flush        <= (pc_sel == PC_SEL_TRAP) || (pc_sel == PC_SEL_REDIRECT);
      misalign_err <= redirect_misaligned;
      if (redirect_misaligned)
        misalign_addr <= redirect_target;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, trap_valid, fetch_ready;
  logic [31:0] redirect_target, trap_target;
  logic [31:0] pc, pc_plus_inc, misalign_addr;
  logic        pc_valid, flush, misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .fetch_ready     (fetch_ready),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_plus_inc     (pc_plus_inc),
    .flush           (flush),
    .misalign_err    (misalign_err),
    .misalign_addr   (misalign_addr)
  );

  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] rt;
    logic        tv;
    logic [31:0] tt;
    logic        fr;
    logic [31:0] e_pc;
    logic        e_v, e_f, e_me;
    logic [31:0] e_ma;
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  // Reference model state: what the architectural registers should hold.
  logic [31:0] m_pc, m_ma;
  logic        m_v, m_f, m_me;

  function automatic vec_t mk(logic r, logic s, logic rv, logic [31:0] rt,
                              logic tv, logic [31:0] tt, logic fr,
                              logic [31:0] epc, logic ev, logic ef,
                              logic eme, logic [31:0] ema);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rt = rt; v.tv = tv; v.tt = tt;
    v.fr = fr; v.e_pc = epc; v.e_v = ev; v.e_f = ef; v.e_me = eme;
    v.e_ma = ema;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, advances the model by the next-PC rules,
  // and returns after the edge with outputs settled.
  task automatic apply(input logic r, input logic s, input logic rv,
                       input logic [31:0] rt, input logic tv,
                       input logic [31:0] tt, input logic fr);
    logic ok_redir;
    rst = r; stall = s; redirect_valid = rv; redirect_target = rt;
    trap_valid = tv; trap_target = tt; fetch_ready = fr;
    ok_redir = rv && (rt % 4 == 0);
    if (r) begin
      m_pc = 32'h0; m_v = 1'b0; m_f = 1'b0; m_me = 1'b0; m_ma = 32'h0;
    end else begin
      m_f  = tv || ok_redir;
      m_me = !tv && rv && !ok_redir;
      if (m_me) m_ma = rt;
      if (tv)                   m_pc = tt;
      else if (ok_redir)        m_pc = rt;
      else if (rv || s)         m_pc = m_pc;
      else if (m_v && fr)       m_pc = m_pc + 32'd4;
      m_v = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    fetch_ready = 1'b0; redirect_target = '0; trap_target = '0;

    //             rst s  rv rt            tv tt            fr  pc            v  f  me ma
    tbl[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        1, 0, 0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        1, 0, 0, 32'h0);
    tbl[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       1, 0, 0, 32'h0);
    tbl[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       1, 0, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       1, 0, 0, 32'h0);
    tbl[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       1, 0, 0, 32'h0);
    tbl[11] = mk(0, 1, 1, 32'h200,      0, 32'h0,        1, 32'h200,      1, 1, 0, 32'h0);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,      1, 0, 0, 32'h0);
    tbl[13] = mk(0, 1, 1, 32'h200,      1, 32'h100,      1, 32'h100,      1, 1, 0, 32'h0);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      1, 0, 0, 32'h0);
    tbl[15] = mk(0, 0, 1, 32'h202,      0, 32'h0,        1, 32'h100,      1, 0, 1, 32'h202);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      1, 0, 0, 32'h202);
    tbl[17] = mk(0, 0, 1, 32'h300,      0, 32'h0,        0, 32'h300,      1, 1, 0, 32'h202);
    tbl[18] = mk(0, 0, 1, 32'h400,      0, 32'h0,        0, 32'h400,      1, 1, 0, 32'h202);
    tbl[19] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h400,      1, 0, 0, 32'h202);
    tbl[20] = mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 1, 0, 32'h202);
    tbl[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h202);
    tbl[22] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 0, 0, 32'h202);
    tbl[23] = mk(1, 0, 1, 32'h800,      0, 32'h0,        1, 32'h0,        0, 0, 0, 32'h0);
    tbl[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);

    // Directed sequence
    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rt,
            tbl[i].tv, tbl[i].tt, tbl[i].fr);
      chk($sformatf("vec%0d.pc", i),            pc,            tbl[i].e_pc);
      chk($sformatf("vec%0d.pc_valid", i),      32'(pc_valid), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d.pc_plus_inc", i),   pc_plus_inc,   tbl[i].e_pc + 32'd4);
      chk($sformatf("vec%0d.flush", i),         32'(flush),    32'(tbl[i].e_f));
      chk($sformatf("vec%0d.misalign_err", i),  32'(misalign_err), 32'(tbl[i].e_me));
      chk($sformatf("vec%0d.misalign_addr", i), misalign_addr, tbl[i].e_ma);
    end

    // Halfword-misaligned redirect while stalled also reports and holds
    apply(0, 1, 1, 32'h0000_1001, 0, 32'h0, 1);
    chk("odd_redir.pc", pc, 32'h0);
    chk("odd_redir.err", 32'(misalign_err), 32'h1);
    chk("odd_redir.addr", misalign_addr, 32'h0000_1001);
    chk("odd_redir.flush", 32'(flush), 32'h0);
    // Trap alongside misaligned redirect: trap wins, no error
    apply(0, 0, 1, 32'h0000_0302, 1, 32'h0000_0500, 1);
    chk("trap_vs_bad.pc", pc, 32'h500);
    chk("trap_vs_bad.err", 32'(misalign_err), 32'h0);
    chk("trap_vs_bad.flush", 32'(flush), 32'h1);
    chk("trap_vs_bad.addr", misalign_addr, 32'h0000_1001);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic        r, s, rv, tv, fr;
      logic [31:0] rt, tt;
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(3) == 0);
      rv = ($urandom_range(7) == 0);
      tv = ($urandom_range(15) == 0);
      fr = ($urandom_range(3) != 0);
      rt = $urandom;
      if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
      tt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(31) == 0) tt = 32'hFFFF_FFF8;
      apply(r, s, rv, rt, tv, tt, fr);
      chk("rnd.pc",            pc,                m_pc);
      chk("rnd.pc_valid",      32'(pc_valid),     32'(m_v));
      chk("rnd.pc_plus_inc",   pc_plus_inc,       m_pc + 32'd4);
      chk("rnd.flush",         32'(flush),        32'(m_f));
      chk("rnd.misalign_err",  32'(misalign_err), 32'(m_me));
      chk("rnd.misalign_addr", misalign_addr,     m_ma);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
